motion_centroid_tracker: RTL and testbench
==========================================

Name: motion_centroid_tracker

Overview:
- Downstream consumer of the difference engine's per-pixel motion stream (same valid/x/y/diff-bit seen at the bdiff RAM write port).
- Per frame, accumulates motion-pixel count, coordinate sums and bounding box.
- At frame end, runs a sequential divider for the raw centroid, then applies exponential smoothing.
- Publishes smoothed centroid, bounding box and count for the display overlay and LEDs.

Parameters:
- X_WIDTH, 9, pixel x coordinate width.
- Y_WIDTH, 8, pixel y coordinate width.
- IMAGE_W, 320, frame width in pixels.
- IMAGE_H, 240, frame height in pixels.
- MIN_COUNT, 300, minimum motion pixels per frame for a valid detection.
- SMOOTH_SHIFT, 2, smoothing weight exponent; new sample weight is 1/2^SMOOTH_SHIFT.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  synchronous active-low reset.
- pix_valid  in  1  pixel qualifier; one pixel per asserted cycle.
- pix_x  in  X_WIDTH  pixel column.
- pix_y  in  Y_WIDTH  pixel row.
- pix_diff  in  1  1 = motion at this pixel.
- centroid_x  out  X_WIDTH  smoothed centroid column.
- centroid_y  out  Y_WIDTH  smoothed centroid row.
- bbox_x_min, bbox_x_max  out  X_WIDTH  last frame's motion bounding box, columns.
- bbox_y_min, bbox_y_max  out  Y_WIDTH  last frame's motion bounding box, rows.
- motion_count  out  17  motion pixels in last completed frame.
- motion_present  out  1  last completed frame had count >= MIN_COUNT.
- result_valid  out  1  one-cycle pulse when all outputs update.
- busy  out  1  high while divide/smooth sequence runs.
- frame_overrun  out  1  sticky; a frame end arrived while busy.

Behaviour:
- Reset (resetn=0 at posedge) clears:
  - all outputs;
  - accumulators;
  - bbox trackers (min=all-ones, max=0);
  - lock flag;
  - FSM, which goes to ACCUM.
- Reset mid-divide aborts the sequence with no result_valid.
- Accumulation is active in every state whenever pix_valid && pix_diff:
  - count += 1 (17 bits);
  - sum_x += pix_x (25 bits);
  - sum_y += pix_y (24 bits);
  - min/max compare-update.
- Sum and count widths are chosen so a full all-motion 320x240 frame cannot overflow.
- Frame end = pix_valid && pix_x==IMAGE_W-1 && pix_y==IMAGE_H-1.
  - That pixel is included in the snapshot.
  - On the same edge, snapshot registers load the totals including that pixel.
  - Live accumulators and bbox trackers reset to their initial values on that same edge.
  - Accumulation of the next frame starts the following cycle.
- Frame end while busy:
  - snapshot is not overwritten and the accumulators are still cleared;
  - frame_overrun is set and stays set until reset;
  - the in-flight result completes normally.
- FSM:
  - ACCUM: idle; on frame end go to CHECK.
  - CHECK (1 cycle): if snap_count < MIN_COUNT (this includes 0), go to PUBLISH with motion_present=0 and the centroid held. Otherwise go to DIV_X.
  - DIV_X: restoring divider, sum_x / count, one quotient bit per cycle, 25 cycles, MSB first. Quotient truncated, low X_WIDTH bits kept; the result is always < IMAGE_W.
  - DIV_Y: same for sum_y / count, 24 cycles.
  - SMOOTH (1 cycle):
    - lock=0: avg loads the quotient directly and lock is set.
    - lock=1: avg = (avg*(2^S-1) + q) >> S, evaluated in X_WIDTH+S (or Y_WIDTH+S) bits, truncating.
  - PUBLISH (1 cycle):
    - registers count, motion_present and bbox;
    - centroid registers get avg;
    - result_valid=1 for this single cycle;
    - returns to ACCUM.
- busy=1 in CHECK, DIV_X, DIV_Y, SMOOTH, PUBLISH.
- Latency from frame-end edge to result_valid:
  - valid detection: 1 + 25 + 24 + 1 + 1 = 52 cycles;
  - below threshold: 2 cycles.
- Bounding box when count==0: published as min=max=0.
- Outputs hold between PUBLISH events.
- pix_valid=0 cycles are ignored. x/y values outside the image are still accumulated; no range checking.

Test Plan:
- Reset, then a full frame with a 20x20 motion block at x 100..119, y 50..69 (count 400) -> result_valid 52 cycles after the last pixel; centroid (109,59) on first lock; bbox 100..119 / 50..69; motion_present=1.
- Second identical frame but block moved to x 200..219, y 50..69 -> raw q_x=209; smoothed centroid_x=(109*3+209)>>2=134; centroid_y=59.
- Frame with 299 motion pixels after lock -> result_valid 2 cycles after frame end; motion_present=0; centroid unchanged; motion_count=299.
- All-ones frame (76800 pixels) -> no overflow; q_x=159, q_y=119; bbox 0..319 / 0..239.
- Inject a second frame-end pixel 10 cycles into DIV_X -> frame_overrun=1; first result correct; the following frame still accumulates from zero.
- Assert resetn=0 during DIV_Y -> no result_valid; all outputs 0; next full frame behaves as first-lock case.

Source files
------------

// File: rtl/motion_centroid_tracker_if.sv
// Pixel motion stream in, per-frame centroid/bounding-box results out.
interface motion_centroid_tracker_if #(
    parameter int X_WIDTH = 9,
    parameter int Y_WIDTH = 8
);
    logic               pix_valid;
    logic [X_WIDTH-1:0] pix_x;
    logic [Y_WIDTH-1:0] pix_y;
    logic               pix_diff;
    logic [X_WIDTH-1:0] centroid_x;
    logic [Y_WIDTH-1:0] centroid_y;
    logic [X_WIDTH-1:0] bbox_x_min;
    logic [X_WIDTH-1:0] bbox_x_max;
    logic [Y_WIDTH-1:0] bbox_y_min;
    logic [Y_WIDTH-1:0] bbox_y_max;
    logic [16:0]        motion_count;
    logic               motion_present;
    logic               result_valid;
    logic               busy;
    logic               frame_overrun;

    modport master (
        output pix_valid, pix_x, pix_y, pix_diff,
        input  centroid_x, centroid_y, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
        input  motion_count, motion_present, result_valid, busy, frame_overrun
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_diff,
        output centroid_x, centroid_y, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
        output motion_count, motion_present, result_valid, busy, frame_overrun
    );
endinterface

// File: rtl/motion_centroid_tracker.sv
// Per-frame motion statistics: accumulate, divide for the raw centroid,
// smooth exponentially, and publish with the bounding box and pixel count.
module motion_centroid_tracker #(
    parameter int X_WIDTH      = 9,
    parameter int Y_WIDTH      = 8,
    parameter int IMAGE_W      = 320,
    parameter int IMAGE_H      = 240,
    parameter int MIN_COUNT    = 300,
    parameter int SMOOTH_SHIFT = 2
) (
    input logic                       clock,
    input logic                       resetn,
    motion_centroid_tracker_if.slave  bus
);
    localparam int CW  = 17;
    localparam int SXW = 25;
    localparam int SYW = 24;
    localparam int SXS = X_WIDTH + SMOOTH_SHIFT;
    localparam int SYS = Y_WIDTH + SMOOTH_SHIFT;

    typedef enum logic [2:0] {ACCUM, CHECK, DIV_X, DIV_Y, SMOOTH, PUBLISH} state_t;
    state_t state;

    logic [CW-1:0]      acc_count, snap_count, nxt_count;
    logic [SXW-1:0]     acc_sum_x, snap_sum_x, nxt_sum_x;
    logic [SYW-1:0]     acc_sum_y, snap_sum_y, nxt_sum_y;
    logic [X_WIDTH-1:0] acc_x_min, acc_x_max, snap_x_min, snap_x_max, nxt_x_min, nxt_x_max;
    logic [Y_WIDTH-1:0] acc_y_min, acc_y_max, snap_y_min, snap_y_max, nxt_y_min, nxt_y_max;
    logic               hit, frame_end;

    logic [SXW-1:0]     div_n, div_shift;
    logic [CW-1:0]      rem, rem_next;
    logic [CW:0]        trial, diff;
    logic               q_bit;
    logic [4:0]         bit_cnt;

    logic [X_WIDTH-1:0] q_x, avg_x, smooth_x;
    logic [Y_WIDTH-1:0] q_y, avg_y, smooth_y;
    logic [SXS-1:0]     blend_x;
    logic [SYS-1:0]     blend_y;
    logic               lock;

    always_comb begin
        hit       = bus.pix_valid && bus.pix_diff;
        frame_end = bus.pix_valid && (bus.pix_x == X_WIDTH'(IMAGE_W - 1))
                                  && (bus.pix_y == Y_WIDTH'(IMAGE_H - 1));
        nxt_count = acc_count;
        nxt_sum_x = acc_sum_x;
        nxt_sum_y = acc_sum_y;
        nxt_x_min = acc_x_min;
        nxt_x_max = acc_x_max;
        nxt_y_min = acc_y_min;
        nxt_y_max = acc_y_max;
        if (hit) begin
            nxt_count = acc_count + CW'(1);
            nxt_sum_x = acc_sum_x + SXW'(bus.pix_x);
            nxt_sum_y = acc_sum_y + SYW'(bus.pix_y);
            if (bus.pix_x < acc_x_min) nxt_x_min = bus.pix_x;
            if (bus.pix_x > acc_x_max) nxt_x_max = bus.pix_x;
            if (bus.pix_y < acc_y_min) nxt_y_min = bus.pix_y;
            if (bus.pix_y > acc_y_max) nxt_y_max = bus.pix_y;
        end
    end

    // Restoring step: since rem < divisor, trial - divisor never sets the top bit
    // unless it borrowed, so that bit alone decides the quotient bit.
    always_comb begin
        trial     = {rem, div_n[SXW-1]};
        diff      = trial - {1'b0, snap_count};
        q_bit     = ~diff[CW];
        rem_next  = q_bit ? diff[CW-1:0] : trial[CW-1:0];
        div_shift = {div_n[SXW-2:0], q_bit};
    end

    always_comb begin
        blend_x  = (SXS'(avg_x) << SMOOTH_SHIFT) - SXS'(avg_x) + SXS'(q_x);
        blend_y  = (SYS'(avg_y) << SMOOTH_SHIFT) - SYS'(avg_y) + SYS'(q_y);
        smooth_x = X_WIDTH'(blend_x >> SMOOTH_SHIFT);
        smooth_y = Y_WIDTH'(blend_y >> SMOOTH_SHIFT);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state              <= ACCUM;
            acc_count          <= '0;
            acc_sum_x          <= '0;
            acc_sum_y          <= '0;
            acc_x_min          <= '1;
            acc_x_max          <= '0;
            acc_y_min          <= '1;
            acc_y_max          <= '0;
            snap_count         <= '0;
            snap_sum_x         <= '0;
            snap_sum_y         <= '0;
            snap_x_min         <= '1;
            snap_x_max         <= '0;
            snap_y_min         <= '1;
            snap_y_max         <= '0;
            div_n              <= '0;
            rem                <= '0;
            bit_cnt            <= '0;
            q_x                <= '0;
            q_y                <= '0;
            avg_x              <= '0;
            avg_y              <= '0;
            lock               <= 1'b0;
            bus.centroid_x     <= '0;
            bus.centroid_y     <= '0;
            bus.bbox_x_min     <= '0;
            bus.bbox_x_max     <= '0;
            bus.bbox_y_min     <= '0;
            bus.bbox_y_max     <= '0;
            bus.motion_count   <= '0;
            bus.motion_present <= 1'b0;
            bus.result_valid   <= 1'b0;
            bus.busy           <= 1'b0;
            bus.frame_overrun  <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            if (frame_end) begin
                acc_count <= '0;
                acc_sum_x <= '0;
                acc_sum_y <= '0;
                acc_x_min <= '1;
                acc_x_max <= '0;
                acc_y_min <= '1;
                acc_y_max <= '0;
                if (state == ACCUM) begin
                    snap_count <= nxt_count;
                    snap_sum_x <= nxt_sum_x;
                    snap_sum_y <= nxt_sum_y;
                    snap_x_min <= nxt_x_min;
                    snap_x_max <= nxt_x_max;
                    snap_y_min <= nxt_y_min;
                    snap_y_max <= nxt_y_max;
                end else begin
                    bus.frame_overrun <= 1'b1;
                end
            end else begin
                acc_count <= nxt_count;
                acc_sum_x <= nxt_sum_x;
                acc_sum_y <= nxt_sum_y;
                acc_x_min <= nxt_x_min;
                acc_x_max <= nxt_x_max;
                acc_y_min <= nxt_y_min;
                acc_y_max <= nxt_y_max;
            end

            case (state)
                ACCUM: begin
                    if (frame_end) begin
                        state    <= CHECK;
                        bus.busy <= 1'b1;
                    end
                end
                CHECK: begin
                    div_n   <= snap_sum_x;
                    rem     <= '0;
                    bit_cnt <= '0;
                    state   <= (snap_count < CW'(MIN_COUNT)) ? PUBLISH : DIV_X;
                end
                DIV_X: begin
                    rem     <= rem_next;
                    div_n   <= div_shift;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'(SXW - 1)) begin
                        q_x     <= div_shift[X_WIDTH-1:0];
                        div_n   <= {snap_sum_y, 1'b0};
                        rem     <= '0;
                        bit_cnt <= '0;
                        state   <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    rem     <= rem_next;
                    div_n   <= div_shift;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'(SYW - 1)) begin
                        q_y   <= div_shift[Y_WIDTH-1:0];
                        state <= SMOOTH;
                    end
                end
                SMOOTH: begin
                    if (!lock) begin
                        avg_x <= q_x;
                        avg_y <= q_y;
                        lock  <= 1'b1;
                    end else begin
                        avg_x <= smooth_x;
                        avg_y <= smooth_y;
                    end
                    state <= PUBLISH;
                end
                PUBLISH: begin
                    bus.motion_count   <= snap_count;
                    bus.motion_present <= (snap_count >= CW'(MIN_COUNT));
                    bus.centroid_x     <= avg_x;
                    bus.centroid_y     <= avg_y;
                    if (snap_count == '0) begin
                        bus.bbox_x_min <= '0;
                        bus.bbox_x_max <= '0;
                        bus.bbox_y_min <= '0;
                        bus.bbox_y_max <= '0;
                    end else begin
                        bus.bbox_x_min <= snap_x_min;
                        bus.bbox_x_max <= snap_x_max;
                        bus.bbox_y_min <= snap_y_min;
                        bus.bbox_y_max <= snap_y_max;
                    end
                    bus.result_valid <= 1'b1;
                    bus.busy         <= 1'b0;
                    state            <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_motion_centroid_tracker.sv
// Directed bench for motion_centroid_tracker: a reference model pushes expected
// per-frame results into a scoreboard that is drained on result_valid.
module tb_motion_centroid_tracker;
    localparam int XW = 9;
    localparam int YW = 8;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;

    motion_centroid_tracker_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

    motion_centroid_tracker #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .IMAGE_W(320), .IMAGE_H(240),
        .MIN_COUNT(300), .SMOOTH_SHIFT(2)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int count, cx, cy, xmin, xmax, ymin, ymax, present, fe, lat;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int m_count, m_sx, m_sy, m_xmin, m_xmax, m_ymin, m_ymax;
    int avg_x = 0, avg_y = 0;
    bit lock = 0;
    int last_fe = -1000, last_lat = 0;
    bit exp_overrun = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_count = 0; m_sx = 0; m_sy = 0;
        m_xmin = 511; m_xmax = 0; m_ymin = 255; m_ymax = 0;
    endtask

    task automatic frame_done(input int s);
        exp_t e;
        int qx, qy;
        if (s > last_fe && s <= last_fe + last_lat) begin
            exp_overrun = 1;
        end else begin
            e.count   = m_count;
            e.present = (m_count >= 300) ? 1 : 0;
            if (e.present == 1) begin
                qx = m_sx / m_count;
                qy = m_sy / m_count;
                if (!lock) begin
                    avg_x = qx; avg_y = qy; lock = 1;
                end else begin
                    avg_x = (avg_x * 3 + qx) / 4;
                    avg_y = (avg_y * 3 + qy) / 4;
                end
                e.lat = 52;
            end else begin
                e.lat = 2;
            end
            e.cx = avg_x; e.cy = avg_y;
            e.xmin = (m_count == 0) ? 0 : m_xmin;
            e.xmax = m_xmax;
            e.ymin = (m_count == 0) ? 0 : m_ymin;
            e.ymax = m_ymax;
            e.fe = s;
            sb.push_back(e);
            last_fe = s; last_lat = e.lat;
        end
        model_clear();
    endtask

    task automatic pix(input int x, input int y, input bit diff, input bit valid);
        @(negedge clock);
        bus.pix_valid = valid;
        bus.pix_x     = XW'(x);
        bus.pix_y     = YW'(y);
        bus.pix_diff  = diff;
        if (valid && diff) begin
            m_count++; m_sx += x; m_sy += y;
            if (x < m_xmin) m_xmin = x;
            if (x > m_xmax) m_xmax = x;
            if (y < m_ymin) m_ymin = y;
            if (y > m_ymax) m_ymax = y;
        end
        if (valid && x == 319 && y == 239) frame_done(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(0, 0, 0, 0);
    endtask

    // Motion block with a masked-off and a no-motion pixel after each row.
    task automatic block(input int x0, input int y0, input int w, input int h);
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) pix(x, y, 1, 1);
            pix(7, 7, 1, 0);
            pix(300, 200, 0, 1);
        end
    endtask

    task automatic frame_end(input bit diff);
        pix(319, 239, diff, 1);
        idle(1);
    endtask

    task automatic wait_results(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("result_timeout", sb.size(), 0);
        check("frame_overrun", bus.frame_overrun, exp_overrun);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cx"}, bus.centroid_x, 0);
        check({tag, "_cy"}, bus.centroid_y, 0);
        check({tag, "_bxmin"}, bus.bbox_x_min, 0);
        check({tag, "_bxmax"}, bus.bbox_x_max, 0);
        check({tag, "_bymin"}, bus.bbox_y_min, 0);
        check({tag, "_bymax"}, bus.bbox_y_max, 0);
        check({tag, "_count"}, bus.motion_count, 0);
        check({tag, "_present"}, bus.motion_present, 0);
        check({tag, "_rv"}, bus.result_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_overrun"}, bus.frame_overrun, 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.result_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_result_valid", bus.result_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc - e.fe, e.lat);
                    check("motion_count", bus.motion_count, e.count);
                    check("motion_present", bus.motion_present, e.present);
                    check("centroid_x", bus.centroid_x, e.cx);
                    check("centroid_y", bus.centroid_y, e.cy);
                    check("bbox_x_min", bus.bbox_x_min, e.xmin);
                    check("bbox_x_max", bus.bbox_x_max, e.xmax);
                    check("bbox_y_min", bus.bbox_y_min, e.ymin);
                    check("bbox_y_max", bus.bbox_y_max, e.ymax);
                end
            end
        end
    endtask

    initial begin
        bus.pix_valid = 0; bus.pix_x = '0; bus.pix_y = '0; bus.pix_diff = 0;
        model_clear();
        fork
            monitor();
        join_none

        idle(3);
        check_all_zero("reset");
        resetn = 1'b1;

        // First lock: 20x20 block at 100..119 / 50..69
        block(100, 50, 20, 20);
        frame_end(0);
        check("busy_during_seq", bus.busy, 1);
        wait_results(100);
        check("busy_after_seq", bus.busy, 0);
        check("first_lock_cx", bus.centroid_x, 109);
        check("first_lock_cy", bus.centroid_y, 59);

        // Block moved right: smoothed toward the new raw centroid
        block(200, 50, 20, 20);
        frame_end(0);
        wait_results(100);
        check("smooth_cx", bus.centroid_x, 134);
        check("smooth_cy", bus.centroid_y, 59);

        // 299 pixels: one below the detection threshold
        block(10, 10, 23, 13);
        frame_end(0);
        wait_results(20);
        check("below_min_count", bus.motion_count, 299);
        check("below_min_cx_held", bus.centroid_x, 134);

        // Entire frame in motion
        for (int y = 0; y < 240; y++)
            for (int x = 0; x < 320; x++) pix(x, y, 1, 1);
        idle(1);
        wait_results(100);
        check("full_count", bus.motion_count, 76800);
        check("full_bxmax", bus.bbox_x_max, 319);
        check("full_bymax", bus.bbox_y_max, 239);

        // Second frame end arrives during DIV_X
        block(50, 30, 20, 20);
        frame_end(0);
        idle(6);
        pix(5, 5, 1, 1); pix(6, 5, 1, 1); pix(7, 5, 1, 1);
        frame_end(1);
        check("overrun_set", bus.frame_overrun, 1);
        wait_results(100);
        block(150, 100, 20, 20);
        frame_end(0);
        wait_results(100);
        check("after_overrun_count", bus.motion_count, 400);

        // Reset while DIV_Y is running
        block(60, 60, 20, 20);
        frame_end(0);
        idle(35);
        resetn = 1'b0;
        sb.delete();
        idle(2);
        check_all_zero("mid_reset");
        resetn = 1'b1;
        lock = 0; avg_x = 0; avg_y = 0;
        last_fe = -1000; last_lat = 0; exp_overrun = 0;
        model_clear();
        idle(60);
        block(100, 50, 20, 20);
        frame_end(0);
        wait_results(100);
        check("relock_cx", bus.centroid_x, 109);
        check("relock_cy", bus.centroid_y, 59);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
